stream_mux_n: RTL and testbench

STREAM_MUX_N -- requirements
Module: stream_mux_n

---
 rtl/stream_mux_n_pkg.sv | 8 +
 rtl/stream_mux_n_if.sv | 24 ++
 rtl/stream_mux_n_rr_arbiter.sv | 35 +++
 rtl/stream_mux_n.sv | 52 +++++
 tb/tb_stream_mux_n.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_n_pkg.sv
// stream_mux_pkg: mode encodings and channel-index width helper for stream_mux_n.
package stream_mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR = 1'b1;
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/stream_mux_n_if.sv
// stream_mux_n_if: input channels, select controls and registered output handshake of stream_mux_n.
interface stream_mux_n_if #(
    parameter int WIDTH = 4,
    parameter int NCH = 4
);
    localparam int SELW = stream_mux_pkg::sel_width(NCH);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_ready;
    logic mode;
    logic [SELW-1:0] sel;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0] out_ch;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input in_ready, out_data, out_ch, out_valid
    );
    modport slave (
        input in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// rr_arbiter: rotating-priority grant over req, scanning upward from the channel after the last one served.
module rr_arbiter import stream_mux_pkg::*; #(
    parameter int NCH = 4,
    localparam int SELW = sel_width(NCH)
) (
    input logic clk,
    input logic rst,
    input logic [NCH-1:0] req,
    input logic advance,
    output logic [SELW-1:0] grant,
    output logic grant_vld
);
    logic [SELW-1:0] ptr;
    logic [SELW:0] idx;
    // Scan farthest-first so the nearest requester after ptr is the last write and wins.
    always_comb begin
        grant = '0;
        grant_vld = 1'b0;
        idx = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = {1'b0, ptr} + (SELW+1)'(k);
            idx = (idx >= (SELW+1)'(NCH)) ? idx - (SELW+1)'(NCH) : idx;
            if (req[idx[SELW-1:0]]) begin
                grant = idx[SELW-1:0];
                grant_vld = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= SELW'(NCH - 1);
        else if (advance)
            ptr <= grant;
    end
endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-to-1 stream mux with fixed or round-robin channel select and a one-entry output register.
module stream_mux_n import stream_mux_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int NCH = 4
) (
    input logic clk,
    input logic rst,
    stream_mux_n_if.slave bus
);
    localparam int SELW = sel_width(NCH);
    logic [NCH-1:0] req;
    logic [SELW-1:0] grant;
    logic grant_vld;
    logic load_en;
    logic xfer;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0] ch_q;
    logic valid_q;
    // Fixed mode narrows the request to sel, so the arbiter also tracks the last fixed-mode grant.
    always_comb begin
        req = '0;
        for (int i = 0; i < NCH; i++)
            req[i] = bus.in_valid[i] && (bus.mode == MODE_RR || bus.sel == SELW'(i));
    end
    assign load_en = !valid_q || bus.out_ready;
    assign xfer = load_en && grant_vld && !rst;
    assign bus.in_ready = xfer ? (NCH'(1) << grant) : '0;
    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(req),
        .advance(xfer),
        .grant(grant),
        .grant_vld(grant_vld)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ch_q <= '0;
            valid_q <= 1'b0;
        end else if (xfer) begin
            data_q <= bus.in_data[grant*WIDTH +: WIDTH];
            ch_q <= grant;
            valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
    assign bus.out_data = data_q;
    assign bus.out_ch = ch_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: vector table plus scoreboard-checked sequences for stream_mux_n (NCH=4) and an NCH=3 invalid-select case.
module tb_stream_mux_n;
    import stream_mux_pkg::*;
    localparam int W = 4;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    stream_mux_n_if #(.WIDTH(W), .NCH(N)) bus ();
    stream_mux_n_if #(.WIDTH(W), .NCH(3)) bus3 ();
    stream_mux_n #(.WIDTH(W), .NCH(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    stream_mux_n #(.WIDTH(W), .NCH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0] ch;
    } word_t;
    typedef struct {
        logic md;
        logic [1:0] s;
        logic [3:0] v;
        logic [15:0] d;
        logic [3:0] exp;
    } vec_t;
    word_t q[$];
    vec_t vt[8];
    int total = 0;
    int bad = 0;
    int m_ptr = N - 1;
    logic m_ov = 1'b0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic void model_grant(input logic [3:0] v, input logic md, input logic [1:0] s,
                                        input int ptr, output logic gv, output int g);
        int j;
        gv = 1'b0;
        g = 0;
        if (md == MODE_FIXED) begin
            if (v[s]) begin
                gv = 1'b1;
                g = int'(s);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (ptr + k) % N;
                if (!gv && v[j]) begin
                    gv = 1'b1;
                    g = j;
                end
            end
        end
    endfunction
    // Called at the negedge: checks current outputs, then advances the model across the next posedge.
    task automatic check_cycle();
        logic gv;
        int g;
        logic le;
        logic [N-1:0] er;
        model_grant(bus.in_valid, bus.mode, bus.sel, m_ptr, gv, g);
        le = !m_ov || bus.out_ready;
        er = (le && gv) ? N'(1 << g) : '0;
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0].d));
            chk("out_ch", 32'(bus.out_ch), 32'(q[0].ch));
        end
        if (m_ov && bus.out_ready && q.size() > 0)
            void'(q.pop_front());
        if (le && gv) begin
            q.push_back({bus.in_data[g*W +: W], 2'(g)});
            m_ptr = g;
        end
        m_ov = (le && gv) ? 1'b1 : (bus.out_ready ? 1'b0 : m_ov);
    endtask
    task automatic cyc();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_ch", 32'(bus.out_ch), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_in_ready3", 32'(bus3.in_ready), 0);
        m_ov = 1'b0;
        m_ptr = N - 1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    initial begin
        bus.in_data = '0;
        bus.in_valid = '0;
        bus.mode = MODE_FIXED;
        bus.sel = '0;
        bus.out_ready = 1'b1;
        bus3.in_data = '0;
        bus3.in_valid = '0;
        bus3.mode = MODE_FIXED;
        bus3.sel = '0;
        bus3.out_ready = 1'b1;
        vt[0] = '{MODE_FIXED, 2'd2, 4'b1111, 16'h0A00, 4'b0100};
        vt[1] = '{MODE_FIXED, 2'd0, 4'b1110, 16'h1234, 4'b0000};
        vt[2] = '{MODE_FIXED, 2'd3, 4'b1000, 16'h5678, 4'b1000};
        vt[3] = '{MODE_FIXED, 2'd1, 4'b0010, 16'h9ABC, 4'b0010};
        vt[4] = '{MODE_RR, 2'd2, 4'b1111, 16'hDEF0, 4'b0001};
        vt[5] = '{MODE_RR, 2'd0, 4'b0110, 16'h3C5A, 4'b0010};
        vt[6] = '{MODE_RR, 2'd1, 4'b0000, 16'hFFFF, 4'b0000};
        vt[7] = '{MODE_RR, 2'd3, 4'b1000, 16'h7E81, 4'b1000};
        #2;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = '0;
            do_reset();
            bus.mode = vt[i].md;
            bus.sel = vt[i].s;
            bus.in_valid = vt[i].v;
            bus.in_data = vt[i].d;
            bus.out_ready = 1'b1;
            #1;
            chk("vec_ready", 32'(bus.in_ready), 32'(vt[i].exp));
            cyc();
            bus.in_valid = '0;
            cyc();
        end
        // Fixed-mode output of vector 0 lands next cycle
        do_reset();
        bus.mode = MODE_FIXED;
        bus.sel = 2'd2;
        bus.in_valid = 4'b1111;
        bus.in_data = 16'h0A00;
        cyc();
        chk("fixed_data", 32'(bus.out_data), 32'hA);
        chk("fixed_ch", 32'(bus.out_ch), 2);
        // Reset while a word is held
        bus.mode = MODE_RR;
        bus.out_ready = 1'b0;
        cyc();
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        do_reset();
        // Round-robin fairness, one word per cycle
        bus.mode = MODE_RR;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                chk("rr_ch", 32'(bus.out_ch), 32'((i - 1) % 4));
                chk("rr_valid", 32'(bus.out_valid), 1);
            end
            bus.in_data = 16'($urandom);
            cyc();
        end
        // Backpressure with mode/sel changes while held
        do_reset();
        bus.mode = MODE_RR;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 16'($urandom);
            if (i == 2) begin
                bus.mode = MODE_FIXED;
                bus.sel = 2'd3;
            end
            #1;
            chk("bp_ready", 32'(bus.in_ready), 0);
            cyc();
        end
        bus.mode = MODE_RR;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_next", 32'(bus.in_ready), 32'b0100);
        cyc();
        cyc();
        cyc();
        // Sparse requests and wrap
        do_reset();
        bus.mode = MODE_RR;
        bus.in_valid = 4'b0100;
        #1;
        chk("sparse_2", 32'(bus.in_ready), 32'b0100);
        cyc();
        bus.in_valid = 4'b1001;
        #1;
        chk("wrap_3", 32'(bus.in_ready), 32'b1000);
        cyc();
        #1;
        chk("wrap_0", 32'(bus.in_ready), 32'b0001);
        cyc();
        bus.in_valid = '0;
        cyc();
        cyc();
        // Out-of-range fixed select on NCH=3
        bus3.mode = MODE_FIXED;
        bus3.sel = 2'd3;
        bus3.in_valid = 3'b111;
        bus3.in_data = 12'hABC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("inv_ready", 32'(bus3.in_ready), 0);
            chk("inv_valid", 32'(bus3.out_valid), 0);
        end
        bus3.sel = 2'd1;
        @(negedge clk);
        chk("sel1_ready", 32'(bus3.in_ready), 32'b010);
        @(negedge clk);
        chk("sel1_data", 32'(bus3.out_data), 32'hB);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
